// File: rtl/panel_pkg.sv
// Shared constants, scan state encoding and sizing helper for the panel column scanner.
package panel_pkg;

   localparam int NUM_COLS       = 24;
   localparam int ROW_W          = 8;
   localparam int TIMEOUT_CYCLES = 16;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DISPLAY,
      BLANK
   } scan_state_t;

   // Counter width able to hold n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/panel_scan_ctrl_if.sv
// Message-memory fetch handshake between the column scanner (master) and the memory (slave).
interface panel_scan_ctrl_if #(
   parameter int ADDR_W = 6,
   parameter int ROW_W  = 8
);

   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [ROW_W-1:0]  mem_data;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  mem_data
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      output mem_data
   );

endinterface

// File: rtl/panel_dwell_timer.sv
// Loadable down-counter: start loads DWELL_CYCLES-1, done is high during the last counted cycle.
module panel_dwell_timer
   import panel_pkg::*;
#(
   parameter int DWELL_CYCLES = 2000
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic clr,
   output logic done
);

   localparam int CW = cnt_width(DWELL_CYCLES);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          run_q, run_d;

   assign done = run_q && (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      run_d = run_q;
      if (start) begin
         cnt_d = CW'(DWELL_CYCLES - 1);
         run_d = 1'b1;
      end else if (clr || done) begin
         run_d = 1'b0;
      end else if (run_q) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

endmodule

// File: rtl/panel_scan_ctrl.sv
// Column-scan sequencer: fetch column pattern, light it for a dwell, blank one cycle, advance.
// Define SCAN_TIMEOUT_EN to abort stalled fetches after TIMEOUT_CYCLES and raise a sticky err.
module panel_scan_ctrl #(
   parameter int NUM_COLS        = panel_pkg::NUM_COLS,
   parameter int ROW_W           = panel_pkg::ROW_W,
   parameter int MSG_LEN         = 64,
   parameter int ADDR_W          = 6,
   parameter int DWELL_CYCLES    = 2000,
   parameter int FRAMES_PER_STEP = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 scroll,
   panel_scan_ctrl_if.master    mem,
   output logic [NUM_COLS-1:0]  active_col,
   output logic [ROW_W-1:0]     row_data,
   output logic                 blank,
   output logic [4:0]           col_idx,
   output logic [ADDR_W-1:0]    scroll_offset,
   output logic                 frame_tick,
   output logic                 err
);

   import panel_pkg::*;

   localparam int FW = cnt_width(FRAMES_PER_STEP);

   function automatic logic [ADDR_W-1:0] fetch_addr(input logic [ADDR_W-1:0] off,
                                                    input logic [4:0]        col);
      int unsigned sum;
      sum = 32'(off) + 32'(col);
      return ADDR_W'(sum % MSG_LEN);
   endfunction

   function automatic logic [ADDR_W-1:0] next_offset(input logic [ADDR_W-1:0] off);
      return (off == ADDR_W'(MSG_LEN - 1)) ? '0 : off + ADDR_W'(1);
   endfunction

   scan_state_t          state_q, state_d;
   logic                 mem_req_q, mem_req_d;
   logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
   logic [ROW_W-1:0]     row_data_q, row_data_d;
   logic [NUM_COLS-1:0]  active_col_q, active_col_d;
   logic                 blank_q, blank_d;
   logic [4:0]           col_idx_q, col_idx_d;
   logic [ADDR_W-1:0]    scroll_offset_q, scroll_offset_d;
   logic                 frame_tick_q, frame_tick_d;
   logic [FW-1:0]        frame_cnt_q, frame_cnt_d;

   logic                 start_fetch;
   logic                 fetch_done;
   logic                 dwell_done;
   logic                 col_wrap;

   assign col_wrap = (col_idx_q == 5'(NUM_COLS - 1));

   panel_dwell_timer #(
      .DWELL_CYCLES (DWELL_CYCLES)
   ) u_dwell (
      .clk   (clk),
      .reset (reset),
      .start (fetch_done),
      .clr   (1'b0),
      .done  (dwell_done)
   );

`ifdef SCAN_TIMEOUT_EN
   logic err_q, err_d;
   logic tmo_done;

   // Same counter reused as a watchdog armed on every fetch and cancelled when it completes.
   panel_dwell_timer #(
      .DWELL_CYCLES (TIMEOUT_CYCLES)
   ) u_fetch_tmo (
      .clk   (clk),
      .reset (reset),
      .start (start_fetch),
      .clr   (fetch_done),
      .done  (tmo_done)
   );

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_comb begin
      state_d         = state_q;
      mem_req_d       = mem_req_q;
      mem_addr_d      = mem_addr_q;
      row_data_d      = row_data_q;
      active_col_d    = active_col_q;
      blank_d         = blank_q;
      col_idx_d       = col_idx_q;
      scroll_offset_d = scroll_offset_q;
      frame_tick_d    = 1'b0;
      frame_cnt_d     = frame_cnt_q;
      start_fetch     = 1'b0;
      fetch_done      = 1'b0;
`ifdef SCAN_TIMEOUT_EN
      err_d           = err_q;
`endif

      case (state_q)
         IDLE: begin
            active_col_d = '0;
            blank_d      = 1'b1;
            if (enable) start_fetch = 1'b1;
         end

         FETCH: begin
            if (mem_req_q && mem.mem_ack) begin
               row_data_d = mem.mem_data;
               fetch_done = 1'b1;
            end
`ifdef SCAN_TIMEOUT_EN
            else if (tmo_done) begin
               row_data_d = '0;
               err_d      = 1'b1;
               fetch_done = 1'b1;
            end
`endif
         end

         DISPLAY: begin
            if (dwell_done) begin
               state_d      = BLANK;
               active_col_d = '0;
               blank_d      = 1'b1;
               col_idx_d    = col_wrap ? '0 : col_idx_q + 5'd1;
               if (col_wrap) begin
                  frame_tick_d = 1'b1;
                  // The count parks at its last value while scroll is low so the step fires on
                  // the first wrap after scroll returns.
                  if (frame_cnt_q == FW'(FRAMES_PER_STEP - 1)) begin
                     if (scroll) begin
                        frame_cnt_d     = '0;
                        scroll_offset_d = next_offset(scroll_offset_q);
                     end
                  end else begin
                     frame_cnt_d = frame_cnt_q + FW'(1);
                  end
               end
            end
         end

         BLANK: begin
            if (enable) start_fetch = 1'b1;
            else        state_d     = IDLE;
         end

         default: state_d = IDLE;
      endcase

      // col_idx and scroll_offset already hold their post-BLANK values here.
      if (start_fetch) begin
         state_d    = FETCH;
         mem_req_d  = 1'b1;
         mem_addr_d = fetch_addr(scroll_offset_q, col_idx_q);
      end

      if (fetch_done) begin
         state_d      = DISPLAY;
         mem_req_d    = 1'b0;
         active_col_d = NUM_COLS'(1) << col_idx_q;
         blank_d      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         mem_req_q       <= 1'b0;
         mem_addr_q      <= '0;
         row_data_q      <= '0;
         active_col_q    <= '0;
         blank_q         <= 1'b1;
         col_idx_q       <= '0;
         scroll_offset_q <= '0;
         frame_tick_q    <= 1'b0;
         frame_cnt_q     <= '0;
      end else begin
         state_q         <= state_d;
         mem_req_q       <= mem_req_d;
         mem_addr_q      <= mem_addr_d;
         row_data_q      <= row_data_d;
         active_col_q    <= active_col_d;
         blank_q         <= blank_d;
         col_idx_q       <= col_idx_d;
         scroll_offset_q <= scroll_offset_d;
         frame_tick_q    <= frame_tick_d;
         frame_cnt_q     <= frame_cnt_d;
      end
   end

`ifdef SCAN_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= err_d;
   end
`endif

   assign mem.mem_req    = mem_req_q;
   assign mem.mem_addr   = mem_addr_q;
   assign active_col     = active_col_q;
   assign row_data       = row_data_q;
   assign blank          = blank_q;
   assign col_idx        = col_idx_q;
   assign scroll_offset  = scroll_offset_q;
   assign frame_tick     = frame_tick_q;

endmodule

// File: doc/panel_scan_ctrl.md
Name: panel_scan_ctrl

Overview:
- Column-scan sequencer for the 24-column word panel.
- Walks a one-hot active-column strobe across the panel and fetches each column's row pattern from message memory through a req/ack handshake.
- Holds each column lit for a fixed dwell and inserts a blanking cycle between columns to prevent ghosting.
- Advances a scroll offset every FRAMES_PER_STEP frames when scroll is asserted; sits between the message memory and the column/row drivers.

Parameters:
- NUM_COLS, 24, number of panel columns (one-hot width)
- ROW_W, 8, rows per column (memory data width)
- MSG_LEN, 64, message length in columns; mem_addr wraps modulo MSG_LEN
- ADDR_W, 6, message address width, ≥ clog2(MSG_LEN)
- DWELL_CYCLES, 2000, clocks each column stays lit
- FRAMES_PER_STEP, 8, full frames per scroll step

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  run scanning
- scroll  in  1  allow scroll offset to advance
- mem_req  out  1  fetch request; held high until mem_ack
- mem_addr  out  ADDR_W  column address, stable while mem_req=1
- mem_ack  in  1  data valid; sampled only while mem_req=1
- mem_data  in  ROW_W  row pattern, valid with mem_ack
- active_col  out  NUM_COLS  one-hot column drive; all-zero when blank
- row_data  out  ROW_W  row pattern for the current column
- blank  out  1  1 = drivers off
- col_idx  out  5  current column index, 0..NUM_COLS-1
- scroll_offset  out  ADDR_W  current message start column
- frame_tick  out  1  one-cycle pulse on frame wrap
- err  out  1  sticky fetch-timeout flag (see Optional Feature)

Behaviour:
- Reset values: state=IDLE, active_col=0, row_data=0, blank=1, mem_req=0, col_idx=0, scroll_offset=0, frame_tick=0, err=0, frame count=0, dwell count=0.
- All outputs are registered.
- States: IDLE, FETCH, DISPLAY, BLANK.
- IDLE: blank=1, active_col=0. Goes to FETCH when enable=1.
- FETCH:
  - mem_req=1; mem_addr=(scroll_offset+col_idx) mod MSG_LEN.
  - Earliest mem_ack is 1 cycle after mem_req rises.
  - On mem_ack: capture mem_data into row_data, deassert mem_req next cycle, go to DISPLAY.
  - mem_req is never dropped without ack (unless timeout option is compiled in).
- DISPLAY:
  - active_col=1<<col_idx, blank=0.
  - Stays exactly DWELL_CYCLES cycles, then goes to BLANK.
- BLANK (exactly 1 cycle):
  - active_col=0, blank=1.
  - col_idx increments; NUM_COLS-1 wraps to 0.
  - On wrap: frame_tick=1 for that cycle and the frame count increments.
  - When frame count reaches FRAMES_PER_STEP-1 and scroll=1: frame count goes to 0 and scroll_offset increments, wrapping MSG_LEN-1→0.
  - When scroll=0 at wrap: frame count saturates at FRAMES_PER_STEP-1 and scroll_offset holds.
  - Next state is FETCH if enable=1, else IDLE.
- enable is sampled only in IDLE and BLANK. Deassertion mid-FETCH/DISPLAY completes the column first.
- Column period = 1 (BLANK) + fetch latency + DWELL_CYCLES.
- Simultaneous column wrap and scroll step: the new offset applies to the fetch of column 0.
- reset in any state returns to reset values on the next edge, including mid-handshake (mem_req drops).

Optional Feature:
- Macro: SCAN_TIMEOUT_EN.
- Defined:
  - FETCH aborts after 16 cycles without mem_ack.
  - row_data=0, err is set sticky (cleared only by reset), and the block proceeds to DISPLAY.
- Undefined:
  - FETCH waits indefinitely.
  - err is tied 0.

Decomposition:
- Shared package panel_pkg holds:
  - NUM_COLS=24 and ROW_W=8 constants
  - scan_state_t enum {IDLE, FETCH, DISPLAY, BLANK}
  - TIMEOUT_CYCLES=16
- Sub-module panel_dwell_timer:
  - Loadable down-counter with start input and done pulse, parameterised on DWELL_CYCLES.
  - Also reused for the fetch timeout.

Test Plan (NUM_COLS=24, DWELL_CYCLES=4, FRAMES_PER_STEP=2, MSG_LEN=64, ack 1 cycle after req):
- Reset then enable=1: mem_req at cycle 1, mem_addr=0; ack with data=0xA5 → row_data=0xA5, active_col=24'h000001 for 4 cycles, then 1 blank cycle with active_col=0.
- Run a full frame: active_col walks 1,2,4,…,24'h800000; frame_tick pulses once in the BLANK after col 23; col_idx returns to 0.
- scroll=1 for 2 frames: scroll_offset goes to 1; col 0 fetch uses mem_addr=1. Force offset 63 with col 1: mem_addr=0 (wrap).
- Delay mem_ack 5 cycles: mem_req and mem_addr stay stable, blank=1 throughout; DISPLAY begins the cycle after ack.
- Drop enable mid-DISPLAY: column finishes its 4 cycles, BLANK, then IDLE with mem_req=0. Assert reset mid-FETCH: mem_req=0 and all outputs at reset values next cycle.
- SCAN_TIMEOUT_EN defined, no ack: after 16 cycles err=1, row_data=0, DISPLAY proceeds; err stays 1 until reset.
